// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU issue stage.
//   - ALU Signal encodings (AND/OR/ADD/SUB/SLT) presented to the ALU
//   - ALUOp encodings from the main decoder
//   - R-type funct codes understood by the ALU control decode
//   - occupancy FSM states of the issue-stage skid buffer
package alu_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned REGAW_DEF = 5;

   typedef enum logic [2:0] {
      SIG_AND = 3'b000,
      SIG_OR  = 3'b001,
      SIG_ADD = 3'b010,
      SIG_SUB = 3'b110,
      SIG_SLT = 3'b111
   } alu_sig_e;

   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_SUB     = 2'b01,
      OP_RTYPE   = 2'b10,
      OP_ILLEGAL = 2'b11
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } occ_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: handshake bundle between decode/register read and the ALU.
//   flush                       : discard everything held by the stage
//   in_valid / in_ready         : upstream handshake (in_ready driven by the stage)
//   in_aluop, in_funct, in_alusrc, in_rs, in_rt, in_rs_data, in_rt_data, in_imm
//                               : instruction fields and register-file values
//   out_valid / out_ready       : downstream handshake to the EX stage
//   dataA, dataB, Signal, out_illegal : head entry presented to the ALU
// Modports: slave = the issue stage, master = its environment.
interface alu_issue_stage_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned REGAW = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_aluop;
   logic [5:0]       in_funct;
   logic             in_alusrc;
   logic [REGAW-1:0] in_rs;
   logic [REGAW-1:0] in_rt;
   logic [WIDTH-1:0] in_rs_data;
   logic [WIDTH-1:0] in_rt_data;
   logic [WIDTH-1:0] in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [2:0]       Signal;
   logic             out_illegal;

   modport slave (
      input  flush, in_valid, in_aluop, in_funct, in_alusrc, in_rs, in_rt,
             in_rs_data, in_rt_data, in_imm, out_ready,
      output in_ready, out_valid, dataA, dataB, Signal, out_illegal
   );

   modport master (
      output flush, in_valid, in_aluop, in_funct, in_alusrc, in_rs, in_rt,
             in_rs_data, in_rt_data, in_imm, out_ready,
      input  in_ready, out_valid, dataA, dataB, Signal, out_illegal
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU control.
//   aluop   in  2 : main-decoder ALUOp (00 ADD, 01 SUB, 10 R-type, 11 illegal)
//   funct   in  6 : R-type funct field
//   Signal  out 3 : ALU operation select
//   illegal out 1 : aluop/funct not decodable; Signal falls back to ADD
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] Signal,
   output logic       illegal
);

   always_comb begin
      Signal  = SIG_ADD;
      illegal = 1'b0;
      case (aluop)
         OP_ADD:   Signal = SIG_ADD;
         OP_SUB:   Signal = SIG_SUB;
         OP_RTYPE: begin
            case (funct)
               FUNCT_AND: Signal = SIG_AND;
               FUNCT_OR:  Signal = SIG_OR;
               FUNCT_ADD: Signal = SIG_ADD;
               FUNCT_SUB: Signal = SIG_SUB;
               FUNCT_SLT: Signal = SIG_SLT;
               default:   illegal = 1'b1;
            endcase
         end
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue stage for the 32-bit ALU.
// Decodes ALUOp/funct, selects operands, and holds up to two entries (head + skid)
// so that in_ready is a pure register output.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : alu_issue_stage_if.slave (upstream/downstream handshakes, flush)
// Optional feature, macro FORWARDING_EN: adds fwd_exmem_* / fwd_memwb_* inputs and
// replaces rs/rt register-file values with in-flight results (EX/MEM has priority).
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned REGAW = REGAW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   alu_issue_stage_if.slave bus
`ifdef FORWARDING_EN
   ,
   input  logic             fwd_exmem_we,
   input  logic [REGAW-1:0] fwd_exmem_rd,
   input  logic [WIDTH-1:0] fwd_exmem_data,
   input  logic             fwd_memwb_we,
   input  logic [REGAW-1:0] fwd_memwb_rd,
   input  logic [WIDTH-1:0] fwd_memwb_data
`endif
);

   occ_state_e       state;
   logic             out_valid_q;
   logic             in_ready_q;

   logic [WIDTH-1:0] head_a, head_b, skid_a, skid_b;
   logic [2:0]       head_sig, skid_sig;
   logic             head_ill, skid_ill;

   logic [2:0]       dec_sig;
   logic             dec_ill;
   logic [WIDTH-1:0] rs_val, rt_val, new_b;
   logic             acc, cons;

   alu_ctrl_decode u_decode (
      .aluop   (bus.in_aluop),
      .funct   (bus.in_funct),
      .Signal  (dec_sig),
      .illegal (dec_ill)
   );

`ifdef FORWARDING_EN
   always_comb begin
      rs_val = bus.in_rs_data;
      if (fwd_exmem_we && fwd_exmem_rd == bus.in_rs && bus.in_rs != '0)
         rs_val = fwd_exmem_data;
      else if (fwd_memwb_we && fwd_memwb_rd == bus.in_rs && bus.in_rs != '0)
         rs_val = fwd_memwb_data;

      rt_val = bus.in_rt_data;
      if (fwd_exmem_we && fwd_exmem_rd == bus.in_rt && bus.in_rt != '0)
         rt_val = fwd_exmem_data;
      else if (fwd_memwb_we && fwd_memwb_rd == bus.in_rt && bus.in_rt != '0)
         rt_val = fwd_memwb_data;
   end
`else
   assign rs_val = bus.in_rs_data;
   assign rt_val = bus.in_rt_data;
`endif

   // Immediate path is never forwarded.
   assign new_b = bus.in_alusrc ? bus.in_imm : rt_val;

   assign acc  = bus.in_valid && in_ready_q && !bus.flush;
   assign cons = out_valid_q && bus.out_ready;

   // Occupancy FSM; in_ready/out_valid are registered copies of the next state.
   // Head registers only change on a load, so they hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         head_a      <= '0;
         head_b      <= '0;
         head_sig    <= SIG_ADD;
         head_ill    <= 1'b0;
         skid_a      <= '0;
         skid_b      <= '0;
         skid_sig    <= SIG_ADD;
         skid_ill    <= 1'b0;
      end else if (bus.flush) begin
         state       <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               in_ready_q <= 1'b1;
               if (acc) begin
                  head_a      <= rs_val;
                  head_b      <= new_b;
                  head_sig    <= dec_sig;
                  head_ill    <= dec_ill;
                  state       <= ST_ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && cons) begin
                  head_a   <= rs_val;
                  head_b   <= new_b;
                  head_sig <= dec_sig;
                  head_ill <= dec_ill;
               end else if (acc) begin
                  skid_a     <= rs_val;
                  skid_b     <= new_b;
                  skid_sig   <= dec_sig;
                  skid_ill   <= dec_ill;
                  state      <= ST_TWO;
                  in_ready_q <= 1'b0;
               end else if (cons) begin
                  state       <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_TWO: begin
               if (cons) begin
                  head_a     <= skid_a;
                  head_b     <= skid_b;
                  head_sig   <= skid_sig;
                  head_ill   <= skid_ill;
                  state      <= ST_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.dataA       = head_a;
   assign bus.dataB       = head_b;
   assign bus.Signal      = head_sig;
   assign bus.out_illegal = head_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scenarios plus a random valid/ready/flush soak,
// checked against a queue-based model of the issue stage.
// Build with FORWARDING_EN defined to also exercise the forwarding inputs.
module tb_alu_issue_stage;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  sig;
      logic        ill;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.WIDTH(32), .REGAW(5)) bus ();

`ifdef FORWARDING_EN
   logic        fwd_exmem_we = 1'b0;
   logic [4:0]  fwd_exmem_rd = '0;
   logic [31:0] fwd_exmem_data = '0;
   logic        fwd_memwb_we = 1'b0;
   logic [4:0]  fwd_memwb_rd = '0;
   logic [31:0] fwd_memwb_data = '0;
`endif

   alu_issue_stage #(.WIDTH(32), .REGAW(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus)
`ifdef FORWARDING_EN
      ,
      .fwd_exmem_we   (fwd_exmem_we),
      .fwd_exmem_rd   (fwd_exmem_rd),
      .fwd_exmem_data (fwd_exmem_data),
      .fwd_memwb_we   (fwd_memwb_we),
      .fwd_memwb_rd   (fwd_memwb_rd),
      .fwd_memwb_data (fwd_memwb_data)
`endif
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned obs_cons = 0;
   int unsigned mdl_cons = 0;
   ent_t        q[$];
   bit          post_rst = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fwd_pick(input logic [4:0] r, input logic [31:0] rf);
      if (r == '0) return rf;
`ifdef FORWARDING_EN
      if (fwd_exmem_we && fwd_exmem_rd == r) return fwd_exmem_data;
      if (fwd_memwb_we && fwd_memwb_rd == r) return fwd_memwb_data;
`endif
      return rf;
   endfunction

   // What the ALU should see for the instruction currently on the input side.
   function automatic ent_t ref_entry();
      ent_t e;
      e.a   = fwd_pick(bus.in_rs, bus.in_rs_data);
      e.b   = bus.in_alusrc ? bus.in_imm : fwd_pick(bus.in_rt, bus.in_rt_data);
      e.sig = 3'b010;
      e.ill = 1'b0;
      case (bus.in_aluop)
         2'b00: e.sig = 3'b010;
         2'b01: e.sig = 3'b110;
         2'b10: begin
            case (bus.in_funct)
               6'h24:   e.sig = 3'b000;
               6'h25:   e.sig = 3'b001;
               6'h20:   e.sig = 3'b010;
               6'h22:   e.sig = 3'b110;
               6'h2a:   e.sig = 3'b111;
               default: e.ill = 1'b1;
            endcase
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic compare_outputs();
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, (q.size() < 2) && !post_rst});
      if (q.size() != 0) begin
         check("dataA", bus.dataA, q[0].a);
         check("dataB", bus.dataB, q[0].b);
         check("Signal", {29'd0, bus.Signal}, {29'd0, q[0].sig});
         check("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].ill});
      end
   endtask

   // Inputs are set at a falling edge; advance the model across the next rising
   // edge, then compare at the following falling edge.
   task automatic tick();
      bit   rdy, acc, cons;
      ent_t e;
      rdy  = (q.size() < 2) && !post_rst;
      acc  = bus.in_valid && rdy && !bus.flush;
      cons = (q.size() != 0) && bus.out_ready;
      e    = ref_entry();
      if (bus.out_valid && bus.out_ready && !bus.flush) obs_cons++;
      if (bus.flush) begin
         q.delete();
      end else begin
         if (cons) begin
            mdl_cons++;
            void'(q.pop_front());
         end
         if (acc) q.push_back(e);
      end
      post_rst = 1'b0;
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic put(input logic [1:0] op, input logic [5:0] fn, input logic src,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      bus.in_valid   = 1'b1;
      bus.in_aluop   = op;
      bus.in_funct   = fn;
      bus.in_alusrc  = src;
      bus.in_rs      = 5'd1;
      bus.in_rt      = 5'd2;
      bus.in_rs_data = a;
      bus.in_rt_data = b;
      bus.in_imm     = imm;
`ifdef FORWARDING_EN
      fwd_exmem_we = 1'b0;
      fwd_memwb_we = 1'b0;
`endif
   endtask

   task automatic do_reset(input logic fl);
      rst           = 1'b1;
      bus.flush     = fl;
      bus.in_valid  = fl;
      bus.out_ready = fl;
      @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_dataA", bus.dataA, 32'd0);
      check("rst_dataB", bus.dataB, 32'd0);
      check("rst_Signal", {29'd0, bus.Signal}, 32'd2);
      check("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
      q.delete();
      post_rst     = 1'b1;
      rst          = 1'b0;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
   endtask

   int unsigned saved;
   logic [5:0]  legal_fn [5];

   initial begin
      legal_fn = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a};
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.in_aluop = '0; bus.in_funct = '0; bus.in_alusrc = 1'b0;
      bus.in_rs = '0; bus.in_rt = '0; bus.in_rs_data = '0; bus.in_rt_data = '0; bus.in_imm = '0;

      // Reset, then a SUB R-type held until accepted.
      do_reset(1'b0);
      bus.out_ready = 1'b1;
      put(2'b10, 6'b100010, 1'b0, 32'd9, 32'd4, 32'd0);
      tick();
      check("t1_in_ready_up", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t1_Signal", {29'd0, bus.Signal}, 32'd6);
      check("t1_dataA", bus.dataA, 32'd9);
      check("t1_dataB", bus.dataB, 32'd4);
      check("t1_illegal", {31'd0, bus.out_illegal}, 32'd0);
      drain();

      // Stalled downstream: two accepted, third held upstream, in-order release.
      bus.out_ready = 1'b0;
      put(2'b00, 6'd0, 1'b0, 32'd1, 32'd10, 32'd0); tick();
      put(2'b00, 6'd0, 1'b0, 32'd2, 32'd20, 32'd0); tick();
      check("t2_full_ready", {31'd0, bus.in_ready}, 32'd0);
      put(2'b00, 6'd0, 1'b0, 32'd3, 32'd30, 32'd0);
      repeat (3) begin
         tick();
         check("t2_stall_dataA", bus.dataA, 32'd1);
      end
      bus.out_ready = 1'b1;
      tick();
      check("t2_second", bus.dataA, 32'd2);
      tick();
      check("t2_third", bus.dataA, 32'd3);
      drain();

      // Flush while full, with simultaneous valid and ready.
      bus.out_ready = 1'b0;
      put(2'b01, 6'd0, 1'b0, 32'd7, 32'd8, 32'd0); tick();
      put(2'b01, 6'd0, 1'b0, 32'd5, 32'd6, 32'd0); tick();
      saved = obs_cons;
      bus.flush = 1'b1; bus.out_ready = 1'b1;
      tick();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("t3_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t3_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("t3_delivered", obs_cons, saved);
      drain();

      // Illegal decodes and immediate operand.
      put(2'b11, 6'b100100, 1'b0, 32'd1, 32'd2, 32'd0); tick();
      check("t4_op11_sig", {29'd0, bus.Signal}, 32'd2);
      check("t4_op11_ill", {31'd0, bus.out_illegal}, 32'd1);
      put(2'b10, 6'b000000, 1'b0, 32'd1, 32'd2, 32'd0); tick();
      check("t4_fn0_sig", {29'd0, bus.Signal}, 32'd2);
      check("t4_fn0_ill", {31'd0, bus.out_illegal}, 32'd1);
      put(2'b00, 6'd0, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFC); tick();
      check("t4_imm_sig", {29'd0, bus.Signal}, 32'd2);
      check("t4_imm_dataB", bus.dataB, 32'hFFFF_FFFC);
      drain();

`ifdef FORWARDING_EN
      put(2'b00, 6'd0, 1'b0, 32'h11, 32'h22, 32'h33);
      bus.in_rs = 5'd5;
      fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd5; fwd_exmem_data = 32'hAA;
      fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd5; fwd_memwb_data = 32'hBB;
      tick();
      check("fwd_exmem_prio", bus.dataA, 32'hAA);
      put(2'b00, 6'd0, 1'b0, 32'h44, 32'h22, 32'h33);
      bus.in_rs = 5'd0;
      fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd0; fwd_exmem_data = 32'hAA;
      tick();
      check("fwd_r0", bus.dataA, 32'h44);
      put(2'b00, 6'd0, 1'b1, 32'h44, 32'h22, 32'h1234);
      bus.in_rt = 5'd5;
      fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd5; fwd_exmem_data = 32'hAA;
      tick();
      check("fwd_imm", bus.dataB, 32'h1234);
      drain();
`endif

      // Random soak.
      for (int unsigned i = 0; i < 800; i++) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.out_ready  = ($urandom_range(0, 2) != 0);
         bus.flush      = ($urandom_range(0, 24) == 0);
         bus.in_aluop   = 2'($urandom_range(0, 3));
         bus.in_funct   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
         bus.in_alusrc  = 1'($urandom);
         bus.in_rs      = 5'($urandom_range(0, 3));
         bus.in_rt      = 5'($urandom_range(0, 3));
         bus.in_rs_data = $urandom;
         bus.in_rt_data = $urandom;
         bus.in_imm     = $urandom;
`ifdef FORWARDING_EN
         fwd_exmem_we   = 1'($urandom);
         fwd_exmem_rd   = 5'($urandom_range(0, 3));
         fwd_exmem_data = $urandom;
         fwd_memwb_we   = 1'($urandom);
         fwd_memwb_rd   = 5'($urandom_range(0, 3));
         fwd_memwb_data = $urandom;
`endif
         tick();
      end
      check("soak_delivered", obs_cons, mdl_cons);

      // Reset asserted together with flush, valid and ready.
      do_reset(1'b1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
